// File: rtl/ps2_kbd_decoder_pkg.sv
// Shared scancode constants, state encodings and decode helpers for the
// PS/2 keyboard decoder (scan code set 2).
package ps2_kbd_decoder_pkg;

    localparam logic [7:0] SC_EXT        = 8'hE0;
    localparam logic [7:0] SC_BRK        = 8'hF0;
    localparam logic [7:0] SC_PAUSE      = 8'hE1;
    localparam logic [7:0] SC_ACK        = 8'hFA;
    localparam logic [7:0] SC_RESEND     = 8'hFE;
    localparam logic [7:0] SC_BAT_OK     = 8'hAA;
    localparam logic [7:0] SC_ECHO       = 8'hEE;
    localparam logic [7:0] SC_OVERRUN0   = 8'h00;
    localparam logic [7:0] SC_OVERRUNF   = 8'hFF;
    localparam logic [7:0] SC_SET_LED    = 8'hED;
    localparam logic [7:0] SC_LSHIFT     = 8'h12;
    localparam logic [7:0] SC_RSHIFT     = 8'h59;
    localparam logic [7:0] SC_CTRL       = 8'h14;
    localparam logic [7:0] SC_ALT        = 8'h11;
    localparam logic [7:0] SC_PAUSE_CODE = 8'h77;

    // Bytes that follow E1 in the Pause make sequence before the event is emitted.
    localparam logic [2:0] PAUSE_SKIP    = 3'd7;
    localparam logic [1:0] MAX_RESENDS   = 2'd3;
    localparam int         EV_W          = 10;

    typedef enum logic [2:0] {
        P_IDLE,
        P_EXT,
        P_BRK,
        P_EXT_BRK,
        P_PAUSE
    } parser_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_SEND,
        C_WAIT_TX,
        C_WAIT_ACK
    } cmd_state_t;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_event_t;

    // Keyboard status replies that never represent a key.
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == SC_ACK) || (b == SC_BAT_OK) || (b == SC_ECHO) ||
               (b == SC_RESEND) || (b == SC_OVERRUN0) || (b == SC_OVERRUNF);
    endfunction

    // One-hot position in {ralt, lalt, rctrl, lctrl, rshift, lshift}, or zero.
    function automatic logic [5:0] mod_mask(input logic ext, input logic [7:0] code);
        logic [5:0] m;
        m = 6'b000000;
        if (!ext && code == SC_LSHIFT) m[0] = 1'b1;
        if (!ext && code == SC_RSHIFT) m[1] = 1'b1;
        if (!ext && code == SC_CTRL)   m[2] = 1'b1;
        if ( ext && code == SC_CTRL)   m[3] = 1'b1;
        if (!ext && code == SC_ALT)    m[4] = 1'b1;
        if ( ext && code == SC_ALT)    m[5] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/ps2_kbd_decoder_event_fifo.sv
// First-word fall-through key-event FIFO; a push into a full FIFO without a
// simultaneous pop is dropped and flagged with a one-cycle ovf strobe.
module ps2_kbd_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             ovf
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    // When full, the slot being written is the head being consumed this cycle.
    assign do_push   = push && (!full || do_pop);
    assign head      = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= push && !do_push;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard decoder: set-2 byte parser with modifier tracking, a key-event
// FIFO, and an LED-update command engine with ACK/resend/timeout handling.
module ps2_kbd_decoder
    import ps2_kbd_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 2000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       rx_error,
    output logic [7:0] tx_data,
    output logic       send_req,
    input  logic       tx_busy,
    input  logic [2:0] led,
    input  logic       led_req,
    output logic       led_busy,
    output logic       cmd_err,
    output logic [9:0] ev_data,
    output logic       ev_valid,
    input  logic       ev_pop,
    output logic [5:0] mods,
    output logic       ev_ovf
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    parser_state_t p_state;
    logic [2:0]    skip;
    cmd_state_t    c_state;
    logic [2:0]    led_lat;
    logic          led_phase;
    logic [1:0]    resends;
    logic [TW-1:0] timer;
    logic          tx_busy_q;

    logic          rx_take;
    logic          rx_good;
    logic          ev_gen;
    key_event_t    ev_word;
    logic [5:0]    ev_mask;
    logic          ack_seen;
    logic          resend_seen;

    // While an LED command is in flight every received byte belongs to it.
    assign rx_take     = rx_ready && (c_state == C_IDLE);
    assign rx_good     = rx_take && !rx_error;
    assign ack_seen    = rx_ready && !rx_error && (rx_data == SC_ACK);
    assign resend_seen = rx_ready && !rx_error && (rx_data == SC_RESEND);

    always_comb begin
        ev_gen  = 1'b0;
        ev_word = '0;
        if (rx_good) begin
            case (p_state)
                P_IDLE: begin
                    if (rx_data != SC_EXT && rx_data != SC_BRK &&
                        rx_data != SC_PAUSE && !is_status_byte(rx_data)) begin
                        ev_gen  = 1'b1;
                        ev_word = '{brk: 1'b0, ext: 1'b0, code: rx_data};
                    end
                end
                P_EXT: begin
                    if (rx_data != SC_BRK && rx_data != SC_LSHIFT) begin
                        ev_gen  = 1'b1;
                        ev_word = '{brk: 1'b0, ext: 1'b1, code: rx_data};
                    end
                end
                P_BRK: begin
                    ev_gen  = 1'b1;
                    ev_word = '{brk: 1'b1, ext: 1'b0, code: rx_data};
                end
                P_EXT_BRK: begin
                    if (rx_data != SC_LSHIFT) begin
                        ev_gen  = 1'b1;
                        ev_word = '{brk: 1'b1, ext: 1'b1, code: rx_data};
                    end
                end
                P_PAUSE: begin
                    if (skip == 3'd1) begin
                        ev_gen  = 1'b1;
                        ev_word = '{brk: 1'b0, ext: 1'b1, code: SC_PAUSE_CODE};
                    end
                end
                default: begin
                    ev_gen  = 1'b0;
                    ev_word = '0;
                end
            endcase
        end
    end

    assign ev_mask = mod_mask(ev_word.ext, ev_word.code);

    // Parser state and modifier bitmap; modifiers follow every completed event,
    // including one the FIFO has to drop.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            p_state <= P_IDLE;
            skip    <= 3'd0;
            mods    <= 6'b000000;
        end else begin
            if (rx_take) begin
                if (rx_error) begin
                    p_state <= P_IDLE;
                end else begin
                    case (p_state)
                        P_IDLE: begin
                            if (rx_data == SC_EXT) begin
                                p_state <= P_EXT;
                            end else if (rx_data == SC_BRK) begin
                                p_state <= P_BRK;
                            end else if (rx_data == SC_PAUSE) begin
                                p_state <= P_PAUSE;
                                skip    <= PAUSE_SKIP;
                            end
                        end
                        P_EXT:     p_state <= (rx_data == SC_BRK) ? P_EXT_BRK : P_IDLE;
                        P_BRK:     p_state <= P_IDLE;
                        P_EXT_BRK: p_state <= P_IDLE;
                        P_PAUSE: begin
                            skip <= skip - 1'b1;
                            if (skip == 3'd1) p_state <= P_IDLE;
                        end
                        default:   p_state <= P_IDLE;
                    endcase
                end
            end
            if (ev_gen) begin
                mods <= ev_word.brk ? (mods & ~ev_mask) : (mods | ev_mask);
            end
        end
    end

    // LED command engine: ED then {5'b0, led}, each answered by FA, or FE to resend.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            c_state   <= C_IDLE;
            tx_data   <= 8'h00;
            send_req  <= 1'b0;
            cmd_err   <= 1'b0;
            led_lat   <= 3'b000;
            led_phase <= 1'b0;
            resends   <= 2'd0;
            timer     <= '0;
            tx_busy_q <= 1'b0;
        end else begin
            send_req  <= 1'b0;
            cmd_err   <= 1'b0;
            tx_busy_q <= tx_busy;
            case (c_state)
                C_IDLE: begin
                    if (led_req) begin
                        led_lat   <= led;
                        led_phase <= 1'b0;
                        resends   <= 2'd0;
                        tx_data   <= SC_SET_LED;
                        c_state   <= C_SEND;
                    end
                end
                C_SEND: begin
                    if (!tx_busy) begin
                        send_req <= 1'b1;
                        c_state  <= C_WAIT_TX;
                    end
                end
                C_WAIT_TX: begin
                    if (tx_busy_q && !tx_busy) begin
                        timer   <= TW'(ACK_TIMEOUT);
                        c_state <= C_WAIT_ACK;
                    end
                end
                C_WAIT_ACK: begin
                    if (ack_seen) begin
                        if (led_phase) begin
                            c_state <= C_IDLE;
                        end else begin
                            led_phase <= 1'b1;
                            resends   <= 2'd0;
                            tx_data   <= {5'b00000, led_lat};
                            c_state   <= C_SEND;
                        end
                    end else if (resend_seen) begin
                        if (resends == MAX_RESENDS) begin
                            cmd_err <= 1'b1;
                            c_state <= C_IDLE;
                        end else begin
                            resends <= resends + 1'b1;
                            c_state <= C_SEND;
                        end
                    end else if (timer <= TW'(1)) begin
                        cmd_err <= 1'b1;
                        c_state <= C_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: c_state <= C_IDLE;
            endcase
        end
    end

    assign led_busy = (c_state != C_IDLE);

    // ev_valid/ev_pop: ev_data is a valid event whenever ev_valid=1, and it is
    // consumed on any clock edge where ev_pop=1 and ev_valid=1; a pop with
    // ev_valid=0 has no effect.
    ps2_kbd_event_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(EV_W)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (ev_gen),
        .wdata     (ev_word),
        .pop       (ev_pop),
        .head      (ev_data),
        .not_empty (ev_valid),
        .ovf       (ev_ovf)
    );

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: scancode parsing, modifiers, FIFO
// overflow and the LED command handshake, checked through scoreboards.
module tb_ps2_kbd_decoder;
    localparam int DEPTH = 4;
    localparam int TMO   = 40;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_error;
    logic [7:0] tx_data;
    logic       send_req;
    logic       tx_busy;
    logic [2:0] led;
    logic       led_req;
    logic       led_busy;
    logic       cmd_err;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       ev_pop;
    logic [5:0] mods;
    logic       ev_ovf;

    logic [9:0] exp_q[$];
    logic [7:0] exp_tx_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic       auto_pop = 1'b1;
    int         tx_done = 0;
    int         err_cnt = 0;
    int         ovf_cnt = 0;
    int         cyc = 0;
    int         fall_cyc = 0;

    ps2_kbd_decoder #(
        .FIFO_DEPTH  (DEPTH),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_error  (rx_error),
        .tx_data   (tx_data),
        .send_req  (send_req),
        .tx_busy   (tx_busy),
        .led       (led),
        .led_req   (led_req),
        .led_busy  (led_busy),
        .cmd_err   (cmd_err),
        .ev_data   (ev_data),
        .ev_valid  (ev_valid),
        .ev_pop    (ev_pop),
        .mods      (mods),
        .ev_ovf    (ev_ovf)
    );

    // ---------------- clock / reset ----------------
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        forever begin
            @(posedge sys_clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "bench time limit expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse counters for one-cycle strobes.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (cmd_err === 1'b1) err_cnt++;
            if (ev_ovf === 1'b1)  ovf_cnt++;
        end
    end

    // Event monitor: pops the FIFO head and compares it with the expected queue.
    initial begin
        ev_pop = 1'b0;
        forever begin
            @(negedge sys_clk);
            ev_pop = 1'b0;
            if (auto_pop && ev_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL ev_unexpected: got 0x%0h, expected no event", ev_data);
                end else begin
                    check("ev_data", ev_data, exp_q.pop_front());
                end
                ev_pop = 1'b1;
            end
        end
    end

    // Host transmitter model: logs each command byte, then busy for 4 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (send_req === 1'b1) begin
                if (exp_tx_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got 0x%0h, expected no command", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_tx_q.pop_front());
                end
                tx_busy = 1'b1;
                @(negedge sys_clk);
                check("send_req_width", send_req, 0);
                repeat (3) @(negedge sys_clk);
                tx_busy  = 1'b0;
                fall_cyc = cyc;
                tx_done++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rx_byte(input logic [7:0] b, input logic err);
        @(posedge sys_clk);
        #1;
        rx_data  = b;
        rx_error = err;
        rx_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_ready = 1'b0;
        rx_error = 1'b0;
    endtask

    // One byte; checks the event appears exactly one cycle later (or not at all).
    task automatic step(input logic [7:0] b, input logic has_ev, input logic [9:0] ev,
                        input logic [5:0] exp_mods);
        if (has_ev) exp_q.push_back(ev);
        rx_byte(b, 1'b0);
        @(negedge sys_clk);
        check("ev_latency", ev_valid, has_ev);
        check("mods", mods, exp_mods);
        repeat (2) @(posedge sys_clk);
    endtask

    task automatic pulse_led(input logic [2:0] val);
        @(posedge sys_clk);
        #1;
        led     = val;
        led_req = 1'b1;
        @(posedge sys_clk);
        #1;
        led_req = 1'b0;
        led     = 3'b000;
    endtask

    task automatic wait_tx(input int target);
        int i;
        i = 0;
        while (tx_done < target && i < 300) begin
            @(negedge sys_clk);
            i++;
        end
        check("tx_wait", (tx_done >= target), 1);
    endtask

    task automatic reply(input logic [7:0] b);
        repeat (2) @(posedge sys_clk);
        rx_byte(b, 1'b0);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 100) begin
            @(negedge sys_clk);
            i++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_tx;
        int base_err;
        int found;

        sys_rst_n = 1'b0;
        rx_data   = 8'h00;
        rx_ready  = 1'b0;
        rx_error  = 1'b0;
        led       = 3'b000;
        led_req   = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_data", ev_data, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_send_req", send_req, 0);
        check("rst_led_busy", led_busy, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_mods", mods, 0);
        check("rst_ev_ovf", ev_ovf, 0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        // make / break
        step(8'h1C, 1'b1, 10'h01C, 6'b000000);
        step(8'hF0, 1'b0, 10'h000, 6'b000000);
        step(8'h1C, 1'b1, 10'h21C, 6'b000000);
        // extended break, fake shift dropped, extended make
        step(8'hE0, 1'b0, 10'h000, 6'b000000);
        step(8'hF0, 1'b0, 10'h000, 6'b000000);
        step(8'h7C, 1'b1, 10'h37C, 6'b000000);
        step(8'hE0, 1'b0, 10'h000, 6'b000000);
        step(8'h12, 1'b0, 10'h000, 6'b000000);
        step(8'hE0, 1'b0, 10'h000, 6'b000000);
        step(8'h7C, 1'b1, 10'h17C, 6'b000000);
        // modifiers
        step(8'h12, 1'b1, 10'h012, 6'b000001);
        step(8'hF0, 1'b0, 10'h000, 6'b000001);
        step(8'h12, 1'b1, 10'h212, 6'b000000);
        step(8'hE0, 1'b0, 10'h000, 6'b000000);
        step(8'h14, 1'b1, 10'h114, 6'b001000);
        step(8'h59, 1'b1, 10'h059, 6'b001010);
        step(8'h11, 1'b1, 10'h011, 6'b011010);
        step(8'hE0, 1'b0, 10'h000, 6'b011010);
        step(8'h11, 1'b1, 10'h111, 6'b111010);
        step(8'h14, 1'b1, 10'h014, 6'b111110);
        step(8'hE0, 1'b0, 10'h000, 6'b111110);
        step(8'hF0, 1'b0, 10'h000, 6'b111110);
        step(8'h14, 1'b1, 10'h314, 6'b110110);
        step(8'hF0, 1'b0, 10'h000, 6'b110110);
        step(8'h59, 1'b1, 10'h259, 6'b110100);
        step(8'hF0, 1'b0, 10'h000, 6'b110100);
        step(8'h11, 1'b1, 10'h211, 6'b100100);
        step(8'hF0, 1'b0, 10'h000, 6'b100100);
        step(8'h14, 1'b1, 10'h214, 6'b100000);
        step(8'hE0, 1'b0, 10'h000, 6'b100000);
        step(8'hF0, 1'b0, 10'h000, 6'b100000);
        step(8'h11, 1'b1, 10'h311, 6'b000000);
        // Pause: eight bytes, one event on the last
        step(8'hE1, 1'b0, 10'h000, 6'b000000);
        step(8'h14, 1'b0, 10'h000, 6'b000000);
        step(8'h77, 1'b0, 10'h000, 6'b000000);
        step(8'hE1, 1'b0, 10'h000, 6'b000000);
        step(8'hF0, 1'b0, 10'h000, 6'b000000);
        step(8'h14, 1'b0, 10'h000, 6'b000000);
        step(8'hF0, 1'b0, 10'h000, 6'b000000);
        step(8'h77, 1'b1, 10'h177, 6'b000000);
        // status bytes are discarded
        step(8'hFA, 1'b0, 10'h000, 6'b000000);
        step(8'hAA, 1'b0, 10'h000, 6'b000000);
        step(8'hEE, 1'b0, 10'h000, 6'b000000);
        step(8'hFE, 1'b0, 10'h000, 6'b000000);
        step(8'h00, 1'b0, 10'h000, 6'b000000);
        step(8'hFF, 1'b0, 10'h000, 6'b000000);
        // rx_error discards the byte and resyncs to idle
        step(8'hE0, 1'b0, 10'h000, 6'b000000);
        rx_byte(8'h7C, 1'b1);
        @(negedge sys_clk);
        check("err_no_event", ev_valid, 0);
        step(8'h1C, 1'b1, 10'h01C, 6'b000000);
        drain();

        // overflow: five events into a four-entry FIFO with no pops
        auto_pop = 1'b0;
        ovf_cnt  = 0;
        @(negedge sys_clk);
        exp_q.push_back(10'h015);
        exp_q.push_back(10'h016);
        exp_q.push_back(10'h01A);
        exp_q.push_back(10'h01B);
        rx_byte(8'h15, 1'b0);
        rx_byte(8'h16, 1'b0);
        rx_byte(8'h1A, 1'b0);
        rx_byte(8'h1B, 1'b0);
        @(negedge sys_clk);
        check("ovf_before_full", ovf_cnt, 0);
        rx_byte(8'h1D, 1'b0);
        repeat (3) @(negedge sys_clk);
        check("ovf_pulses", ovf_cnt, 1);
        check("ovf_head_valid", ev_valid, 1);
        check("ovf_head", ev_data, 10'h015);
        auto_pop = 1'b1;
        drain();

        // LED update: ED, 05, then FE forces a resend of 05
        base_tx  = tx_done;
        base_err = err_cnt;
        exp_tx_q.push_back(8'hED);
        exp_tx_q.push_back(8'h05);
        exp_tx_q.push_back(8'h05);
        pulse_led(3'b101);
        @(negedge sys_clk);
        check("led_busy_set", led_busy, 1);
        wait_tx(base_tx + 1);
        pulse_led(3'b011);
        rx_byte(8'h1C, 1'b0);
        reply(8'hFA);
        wait_tx(base_tx + 2);
        reply(8'hFE);
        wait_tx(base_tx + 3);
        reply(8'hFA);
        repeat (3) @(negedge sys_clk);
        check("led_busy_clear", led_busy, 0);
        check("led_cmd_err", err_cnt - base_err, 0);
        check("led_tx_all_sent", exp_tx_q.size(), 0);
        repeat (10) @(negedge sys_clk);
        check("led_no_extra_tx", tx_done - base_tx, 3);
        step(8'h1C, 1'b1, 10'h01C, 6'b000000);

        // Four FE replies to ED: three resends, then cmd_err
        base_tx  = tx_done;
        base_err = err_cnt;
        for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'hED);
        pulse_led(3'b111);
        for (int i = 1; i <= 4; i++) begin
            wait_tx(base_tx + i);
            reply(8'hFE);
        end
        repeat (3) @(negedge sys_clk);
        check("resend_cmd_err", err_cnt - base_err, 1);
        check("resend_led_busy", led_busy, 0);
        check("resend_tx_count", tx_done - base_tx, 4);

        // No reply: cmd_err after ACK_TIMEOUT cycles in the wait-for-ACK state
        base_tx  = tx_done;
        base_err = err_cnt;
        exp_tx_q.push_back(8'hED);
        pulse_led(3'b010);
        wait_tx(base_tx + 1);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge sys_clk);
            if (cmd_err === 1'b1) found = 1;
        end
        check("timeout_seen", found, 1);
        // Busy falls before edge E; ACK wait spans edges E..E+TMO.
        check("timeout_cycles", cyc - fall_cyc, TMO + 1);
        @(negedge sys_clk);
        check("timeout_led_busy", led_busy, 0);
        check("timeout_err_count", err_cnt - base_err, 1);

        drain();
        check("ovf_total", ovf_cnt, 1);
        check("tx_queue_empty", exp_tx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
